// File: rtl/step_sequencer.sv
// Multi-step validation sequencer: walks N_STEPS qualification steps in order,
// then waits for a closing finish, reporting completion, errors and a sequence count.
module step_sequencer #(
  parameter int N_STEPS = 3,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 16,
  parameter int STRICT  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_STEPS-1:0] valid,
  input  logic               finish,
  input  logic               abort,
  output logic [N_STEPS-1:0] step_pulse,
  output logic               done,
  output logic               busy,
  output logic [3:0]         cur_step,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [7:0]         seq_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STEP     = 2'd1,
    S_WAIT_END = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  localparam bit              TO_EN     = (TIMEOUT != 0);
  localparam bit              STRICT_EN = (STRICT != 0);
  localparam logic [3:0]      LAST_IDX  = 4'(N_STEPS - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  // NOTE: declaration initialisers give the power-up state; they match the reset values exactly.
  state_t             r_state      = S_IDLE;
  logic [3:0]         r_idx        = '0;
  logic [TO_W-1:0]    r_cnt        = '0;
  logic [N_STEPS-1:0] r_step_pulse = '0;
  logic               r_done       = 1'b0;
  logic               r_busy       = 1'b0;
  logic               r_err        = 1'b0;
  logic [1:0]         r_err_code   = ERR_NONE;
  logic [7:0]         r_seq_count  = '0;

  logic [N_STEPS-1:0] w_sel;
  logic [N_STEPS-1:0] w_above;
  logic               w_hit;
  logic               w_order;
  logic               w_expire;
  logic               w_last;
  logic               w_fail;
  logic [1:0]         w_fail_code;

  // One-hot of the awaited step, and a mask of every step beyond it.
  always_comb begin
    w_sel   = '0;
    w_above = '0;
    for (int i = 0; i < N_STEPS; i++) begin
      w_sel[i]   = (4'(i) == r_idx);
      w_above[i] = (4'(i) > r_idx);
    end
  end

  assign w_hit    = |(valid & w_sel);
  assign w_order  = STRICT_EN && (|(valid & w_above));
  assign w_expire = TO_EN && (r_cnt == TO_LAST);
  assign w_last   = (r_idx == LAST_IDX);

  // Error priority: abort beats everything; a qualifying valid beats order and timeout.
  always_comb begin
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    if (r_state != S_IDLE && abort) begin
      w_fail      = 1'b1;
      w_fail_code = ERR_ABORT;
    end else if (r_state == S_STEP && !w_hit) begin
      if (w_order) begin
        w_fail      = 1'b1;
        w_fail_code = ERR_ORDER;
      end else if (w_expire) begin
        w_fail      = 1'b1;
        w_fail_code = ERR_TIMEOUT;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_step_pulse <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_seq_count  <= '0;
    end else begin
      r_step_pulse <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      if (w_fail) begin
        r_state    <= S_IDLE;
        r_idx      <= '0;
        r_cnt      <= '0;
        r_busy     <= 1'b0;
        r_err      <= 1'b1;
        r_err_code <= w_fail_code;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state    <= S_STEP;
              r_idx      <= '0;
              r_cnt      <= '0;
              r_busy     <= 1'b1;
              r_err_code <= ERR_NONE;
            end
          end
          S_STEP: begin
            if (w_hit) begin
              r_step_pulse <= w_sel;
              r_cnt        <= '0;
              if (w_last) begin
                r_state <= S_WAIT_END;
                r_idx   <= '0;
              end else begin
                r_idx <= r_idx + 4'd1;
              end
            end else if (TO_EN) begin
              r_cnt <= r_cnt + TO_W'(1);
            end
          end
          S_WAIT_END: begin
            if (finish) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_seq_count <= r_seq_count + 8'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign step_pulse = r_step_pulse;
  assign done       = r_done;
  assign busy       = r_busy;
  assign cur_step   = r_idx;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign seq_count  = r_seq_count;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: a strict and a lax instance share stimulus; a
// rule-level model per instance is compared every cycle, plus literal spot checks.
module tb_step_sequencer;

  localparam int N  = 3;
  localparam int TO = 8;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         start  = 1'b0;
  logic [N-1:0] valid  = '0;
  logic         finish = 1'b0;
  logic         abort  = 1'b0;

  logic [N-1:0] sp0, sp1;
  logic         dn0, dn1, bz0, bz1, er0, er1;
  logic [3:0]   cs0, cs1;
  logic [1:0]   ec0, ec1;
  logic [7:0]   sc0, sc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  step_sequencer #(.N_STEPS(N), .TIMEOUT(TO), .TO_W(16), .STRICT(1)) u_strict (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .finish(finish), .abort(abort),
    .step_pulse(sp0), .done(dn0), .busy(bz0), .cur_step(cs0), .err(er0),
    .err_code(ec0), .seq_count(sc0)
  );

  step_sequencer #(.N_STEPS(N), .TIMEOUT(TO), .TO_W(16), .STRICT(0)) u_lax (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .finish(finish), .abort(abort),
    .step_pulse(sp1), .done(dn1), .busy(bz1), .cur_step(cs1), .err(er1),
    .err_code(ec1), .seq_count(sc1)
  );

  // Model: phase 0 idle, 1 stepping, 2 awaiting finish; m_wait counts idle cycles in a step.
  int         m_phase [2] = '{0, 0};
  int         m_idx   [2] = '{0, 0};
  int         m_wait  [2] = '{0, 0};
  int         m_code  [2] = '{0, 0};
  int         m_count [2] = '{0, 0};
  logic [2:0] m_pulse [2] = '{3'b0, 3'b0};
  bit         m_done  [2] = '{1'b0, 1'b0};
  bit         m_err   [2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_fail(input int d, input int code);
    m_phase[d] = 0;
    m_idx[d]   = 0;
    m_wait[d]  = 0;
    m_err[d]   = 1'b1;
    m_code[d]  = code;
  endfunction

  function automatic void model_edge(input int d, input bit strict);
    m_pulse[d] = '0;
    m_done[d]  = 1'b0;
    m_err[d]   = 1'b0;
    if (reset) begin
      m_phase[d] = 0; m_idx[d] = 0; m_wait[d] = 0; m_code[d] = 0; m_count[d] = 0;
      return;
    end
    case (m_phase[d])
      0: if (start) begin
        m_phase[d] = 1; m_idx[d] = 0; m_wait[d] = 0; m_code[d] = 0;
      end
      1: begin
        if (abort) model_fail(d, 3);
        else if (valid[m_idx[d]]) begin
          m_pulse[d] = 3'(1 << m_idx[d]);
          m_idx[d]++;
          m_wait[d] = 0;
          if (m_idx[d] == N) begin
            m_phase[d] = 2;
            m_idx[d]   = 0;
          end
        end else if (strict && ((valid >> (m_idx[d] + 1)) != 0)) model_fail(d, 2);
        else if (m_wait[d] + 1 == TO) model_fail(d, 1);
        else m_wait[d]++;
      end
      default: begin
        if (abort) model_fail(d, 3);
        else if (finish) begin
          m_phase[d] = 0;
          m_done[d]  = 1'b1;
          m_count[d] = (m_count[d] + 1) % 256;
        end
      end
    endcase
  endfunction

  task automatic compare(input int d, input logic [2:0] sp, input logic dn, input logic bz,
                         input logic [3:0] cs, input logic er, input logic [1:0] ec,
                         input logic [7:0] sc);
    check($sformatf("d%0d step_pulse", d), sp, m_pulse[d]);
    check($sformatf("d%0d done", d), dn, m_done[d]);
    check($sformatf("d%0d busy", d), bz, m_phase[d] != 0);
    check($sformatf("d%0d cur_step", d), cs, (m_phase[d] == 1) ? m_idx[d] : 0);
    check($sformatf("d%0d err", d), er, m_err[d]);
    check($sformatf("d%0d err_code", d), ec, m_code[d]);
    check($sformatf("d%0d seq_count", d), sc, m_count[d]);
  endtask

  always @(posedge clk) begin
    model_edge(0, 1'b1);
    model_edge(1, 1'b0);
  end

  always @(negedge clk) begin
    compare(0, sp0, dn0, bz0, cs0, er0, ec0, sc0);
    compare(1, sp1, dn1, bz1, cs1, er1, ec1, sc1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_seq();
    start = 1'b1; tick(); start = 1'b0;
    valid = 3'b001; tick();
    valid = 3'b010; tick();
    valid = 3'b100; tick();
    valid = 3'b000; finish = 1'b1; tick(); finish = 1'b0;
  endtask

  initial begin
    tick();
    check("powerup busy", bz0, 0);
    check("powerup seq_count", sc0, 0);
    reset = 1'b1; tick(); tick(); reset = 1'b0;

    // Clean three-step sequence.
    start = 1'b1; tick(); start = 1'b0;
    check("seq busy", bz0, 1);
    check("seq cur0", cs0, 0);
    valid = 3'b001; tick();
    check("seq pulse0", sp0, 3'b001);
    check("seq cur1", cs0, 1);
    valid = 3'b010; tick();
    check("seq pulse1", sp0, 3'b010);
    valid = 3'b100; tick();
    check("seq pulse2", sp0, 3'b100);
    check("seq cur_wait", cs0, 0);
    check("seq busy_wait", bz0, 1);
    valid = 3'b000; finish = 1'b1; tick(); finish = 1'b0;
    check("seq done", dn0, 1);
    check("seq busy_fall", bz0, 0);
    check("seq count1", sc0, 1);
    tick();
    check("seq done_once", dn0, 0);

    // Timeout after 8 idle cycles, then valid winning on the expiry cycle.
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    check("to not_yet", er0, 0);
    check("to still_busy", bz0, 1);
    tick();
    check("to err", er0, 1);
    check("to code", ec0, 2'b01);
    check("to idle", bz0, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("to code_cleared", ec0, 2'b00);
    repeat (7) tick();
    valid = 3'b001; tick(); valid = 3'b000;
    check("to valid_wins", sp0, 3'b001);
    check("to no_err", er0, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort step code", ec0, 2'b11);

    // Out-of-order valid: strict errors, lax ignores.
    start = 1'b1; tick(); start = 1'b0;
    valid = 3'b100; tick(); valid = 3'b000;
    check("order err", er0, 1);
    check("order code", ec0, 2'b10);
    check("lax busy", bz1, 1);
    check("lax cur", cs1, 0);
    check("lax no_err", er1, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle abort no_err", er0, 0);
    check("idle abort code_held", ec0, 2'b10);
    check("lax abort code", ec1, 2'b11);

    // Abort beats finish; start held across the exit edge is not taken there.
    start = 1'b1; tick(); start = 1'b0;
    valid = 3'b001; tick();
    valid = 3'b010; tick();
    valid = 3'b100; tick();
    valid = 3'b000; finish = 1'b1; abort = 1'b1; start = 1'b1; tick();
    finish = 1'b0; abort = 1'b0;
    check("abfin err", er0, 1);
    check("abfin code", ec0, 2'b11);
    check("abfin no_done", dn0, 0);
    check("abfin count", sc0, 1);
    check("abfin start_ignored", bz0, 0);
    tick(); start = 1'b0;
    check("restart busy", bz0, 1);
    check("restart code", ec0, 2'b00);
    abort = 1'b1; tick(); abort = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle abort err", er0, 0);
    check("idle abort busy", bz0, 0);

    // Reset in step 1, then a fresh start.
    start = 1'b1; tick(); start = 1'b0;
    valid = 3'b001; tick(); valid = 3'b000;
    check("rst cur1", cs0, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst pulse", sp0, 0);
    check("rst busy", bz0, 0);
    check("rst cur", cs0, 0);
    check("rst code", ec0, 0);
    check("rst count", sc0, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("rst restart", bz0, 1);
    abort = 1'b1; tick(); abort = 1'b0;

    // seq_count wrap.
    repeat (255) run_seq();
    check("wrap 255", sc0, 255);
    run_seq();
    check("wrap 0", sc0, 0);
    check("wrap done", dn0, 1);

    // Randomised traffic against the model.
    repeat (4000) begin
      int r;
      reset  = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 2) == 0);
      finish = ($urandom_range(0, 2) == 0);
      abort  = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 9);
      if (r < 5)      valid = 3'b000;
      else if (r < 8) valid = 3'(1 << $urandom_range(0, N - 1));
      else            valid = 3'($urandom_range(0, 7));
      tick();
    end

    reset = 1'b0; start = 1'b0; valid = '0; finish = 1'b0; abort = 1'b0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter N_STEPS, default 3, number of validation steps, range 1..16.
REQ-002 Parameter TIMEOUT, default 0, max cycles spent waiting in one step; 0 disables the timeout.
REQ-003 Parameter TO_W, default 16, width of the timeout counter; TIMEOUT SHALL be less than 2**TO_W.
REQ-004 Parameter STRICT, default 0, 1 enables the out-of-order error.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  begin a sequence; sampled only in IDLE.
REQ-008 valid  input  N_STEPS  per-step validation; bit i qualifies step i.
REQ-009 finish  input  1  closes the sequence; sampled only in WAIT_END.
REQ-010 abort  input  1  cancels the sequence from any non-IDLE state.
REQ-011 step_pulse  output  N_STEPS  one-cycle registered pulse; bit i marks completion of step i.
REQ-012 done  output  1  one-cycle registered pulse on sequence completion.
REQ-013 busy  output  1  high in STEP and WAIT_END.
REQ-014 cur_step  output  4  index of the step being waited on; 0 outside STEP.
REQ-015 err  output  1  one-cycle registered pulse on any error exit.
REQ-016 err_code  output  2  00 none, 01 timeout, 10 order, 11 abort; holds until the next accepted start.
REQ-017 seq_count  output  8  count of completed sequences; wraps 255->0.

Function
REQ-018 States: IDLE, STEP, WAIT_END; state, step index and all outputs SHALL be registered.
REQ-019 IDLE: start=1 -> STEP with index 0, timeout counter 0, err_code cleared to 00 at the same edge.
REQ-020 STEP: valid[index]=1 at edge k -> step_pulse[index]=1 during cycle k+1; index+1 and counter cleared at edge k.
REQ-021 STEP, index=N_STEPS-1 and valid[index]=1 -> WAIT_END; cur_step returns to 0.
REQ-022 STEP: valid bits other than valid[index] SHALL be ignored when STRICT=0.
REQ-023 STRICT=1: any valid bit set above index, with valid[index]=0, -> IDLE, err pulse, err_code=10.
REQ-024 STEP: counter increments each cycle without valid[index]; reaching TIMEOUT-1 without valid -> IDLE, err pulse, err_code=01.
REQ-025 If valid[index] and timeout expiry occur in the same cycle, valid SHALL win.
REQ-026 WAIT_END: finish=1 -> IDLE, done pulse next cycle, seq_count+1 at the same edge.
REQ-027 WAIT_END SHALL NOT time out.
REQ-028 abort=1 in STEP or WAIT_END -> IDLE, err pulse, err_code=11; abort SHALL override valid, finish and timeout in that cycle.
REQ-029 abort in IDLE SHALL have no effect.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 After any exit to IDLE, a new sequence SHALL need start sampled in IDLE at least one cycle later; a start held high across the exit edge is not accepted at that edge.
REQ-032 At most one step SHALL complete per cycle; one bit of step_pulse, at most, SHALL be set.

Reset
REQ-033 reset=1 SHALL force IDLE and zero step_pulse, done, busy, cur_step, err, err_code, seq_count and the counter, from any state, including mid-sequence; reset overrides all inputs.
REQ-034 Power-up value of all registers SHALL be the reset value.

Verification (N_STEPS=3, TIMEOUT=8, STRICT=1 unless stated)
REQ-035 start; valid=001, 010, 100 on consecutive cycles; finish -> step_pulse 001, 010, 100 each one cycle late; done one pulse; seq_count 0->1; busy falls with done.
REQ-036 start; hold valid=000 for 8 cycles in step 0 -> err pulse, err_code=01, IDLE; in the same sequence, valid[0] on the expiry cycle -> step_pulse=001, no err.
REQ-037 start; valid=100 in step 0 -> err, err_code=10; repeat with STRICT=0 -> ignored, still waiting on step 0.
REQ-038 abort with finish=1 in WAIT_END -> err_code=11, no done, seq_count unchanged; abort in IDLE -> no response.
REQ-039 256 complete sequences -> seq_count wraps to 0; reset asserted in step 1 -> all outputs zero next cycle, start then accepted.
